// File: rtl/audio_frame_sequencer.sv
// audio_frame_sequencer: collects N signed samples into a frame buffer, then
// resets and starts the min/max engine, waits for done (or a timeout) and
// presents the captured max/min pair on a valid/ready result port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid is never withdrawn before the transfer and the payload
// is held stable while valid is high and ready is low.
module audio_frame_sequencer #(
   parameter int N       = 100,
   parameter int W       = 32,
   parameter int TIMEOUT = N + 8
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_sample,
   output logic [N*W-1:0] mm_audio,
   output logic           mm_reset,
   output logic           mm_start,
   input  logic           mm_done,
   input  logic [W-1:0]   mm_max,
   input  logic [W-1:0]   mm_min,
   output logic           res_valid,
   input  logic           res_ready,
   output logic [W-1:0]   res_max,
   output logic [W-1:0]   res_min,
   output logic           res_err,
   output logic [7:0]     frame_cnt,
   output logic [2:0]     state_dbg
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [PW-1:0] LAST_SLOT = PW'(N - 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FILL    = 3'd0,
      S_CLEAR   = 3'd1,
      S_START   = 3'd2,
      S_WAIT    = 3'd3,
      S_PRESENT = 3'd4
   } state_e;

   state_e                state_q, state_d;
   logic                  run_q;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
   logic [7:0]            frame_cnt_q, frame_cnt_d;
   logic [W-1:0]          res_max_q, res_max_d;
   logic [W-1:0]          res_min_q, res_min_d;
   logic                  res_err_q, res_err_d;
   logic [N-1:0][W-1:0]   buf_q, buf_d;
   logic                  accept;

   // run_q keeps in_ready low and mm_reset high until the first edge after reset.
   assign in_ready  = run_q && (state_q == S_FILL);
   assign mm_reset  = !run_q || (state_q == S_CLEAR);
   assign mm_start  = (state_q == S_START);
   assign res_valid = (state_q == S_PRESENT);
   assign res_max   = res_max_q;
   assign res_min   = res_min_q;
   assign res_err   = res_err_q;
   assign frame_cnt = frame_cnt_q;
   assign mm_audio  = buf_q;
   assign state_dbg = state_q;
   assign accept    = in_valid && in_ready;

   // Next-state logic: fill the buffer, drive the engine, capture and present.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      wait_cnt_d  = wait_cnt_q;
      frame_cnt_d = frame_cnt_q;
      res_max_d   = res_max_q;
      res_min_d   = res_min_q;
      res_err_d   = res_err_q;
      buf_d       = buf_q;
      case (state_q)
         S_FILL: begin
            if (accept) begin
               buf_d[wr_ptr_q] = in_sample;
               if (wr_ptr_q == LAST_SLOT) begin
                  wr_ptr_d = '0;
                  state_d  = S_CLEAR;
               end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
               end
            end
         end
         S_CLEAR: state_d = S_START;
         S_START: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            // done wins over the timeout when both land in the same cycle
            if (mm_done) begin
               res_max_d = mm_max;
               res_min_d = mm_min;
               res_err_d = 1'b0;
               state_d   = S_PRESENT;
            end else if (wait_cnt_q == LAST_WAIT) begin
               res_max_d = mm_max;
               res_min_d = mm_min;
               res_err_d = 1'b1;
               state_d   = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (res_ready) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               state_d     = S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_FILL;
         run_q       <= 1'b0;
         wr_ptr_q    <= '0;
         wait_cnt_q  <= '0;
         frame_cnt_q <= '0;
         res_max_q   <= '0;
         res_min_q   <= '0;
         res_err_q   <= 1'b0;
         buf_q       <= '0;
      end else begin
         state_q     <= state_d;
         run_q       <= 1'b1;
         wr_ptr_q    <= wr_ptr_d;
         wait_cnt_q  <= wait_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         res_max_q   <= res_max_d;
         res_min_q   <= res_min_d;
         res_err_q   <= res_err_d;
         buf_q       <= buf_d;
      end
   end

endmodule
